// File: rtl/seg_pkg.sv
// Shared seven-segment types: glyph table, scan FSM states, dark pattern.
// Segment bit order is {g,f,e,d,c,b,a}, all active-low.
package seg_pkg;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  typedef enum logic [1:0] {
    IDLE,
    BLANK,
    SHOW
  } state_e;

  localparam logic [6:0] GLYPH [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03,
    7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/hex_to_seg.sv
// Hex nibble to active-low seven-segment glyph.
// Ports: nib (4-bit value), seg (segments {g..a}, active-low).
module hex_to_seg
  import seg_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  assign seg = GLYPH[nib];

endmodule

// File: rtl/seven_seg_scanner.sv
// Multiplexed N-digit common-anode scanner with frame-synchronous load.
// Ports: clk_in, reset (async, active-low), enable, load_valid/
// load_ready/load_data/load_dp handshake, seg, dp, an (all active-low),
// frame_done pulse. Define SEGSCAN_LZB_EN for leading-zero blanking.
module seven_seg_scanner
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int SCAN_DIV     = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic                    clk_in,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [4*NUM_DIGITS-1:0] load_data,
  input  logic [NUM_DIGITS-1:0]   load_dp,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int MAXC = (SCAN_DIV > BLANK_CYCLES)
                      ? SCAN_DIV : BLANK_CYCLES;
  localparam int CW = $clog2(MAXC + 1);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int DW = 4 * NUM_DIGITS;
  localparam int BL = (BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0;

  localparam logic [CW-1:0] SHOW_LAST  = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BL);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
  // With no blank interval each slot goes straight to SHOW.
  localparam state_e POST = (BLANK_CYCLES == 0) ? SHOW : BLANK;

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [DW-1:0]         disp_q, disp_d;
  logic [DW-1:0]         pend_q, pend_d;
  logic [NUM_DIGITS-1:0] disp_dp_q, disp_dp_d;
  logic [NUM_DIGITS-1:0] pend_dp_q, pend_dp_d;
  logic                  pend_full_q, pend_full_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic                  fd_q, fd_d;

  logic       start;
  logic       xfer;
  logic [3:0] nib;
  logic       dp_bit;
  logic       lit;
  logic [6:0] glyph;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    idx_d   = idx_q;
    fd_d    = 1'b0;
    start   = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        if (enable) begin
          state_d = POST;
          start   = 1'b1;
        end
      end
      BLANK: begin
        if (cnt_q == BLANK_LAST) begin
          state_d = SHOW;
          cnt_d   = '0;
        end
      end
      SHOW: begin
        if (cnt_q == SHOW_LAST) begin
          state_d = POST;
          cnt_d   = '0;
          if (idx_q == IDX_LAST) begin
            idx_d = '0;
            fd_d  = 1'b1;
            start = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (!enable) begin
      state_d = IDLE;
      cnt_d   = '0;
      idx_d   = '0;
      fd_d    = 1'b0;
      start   = 1'b0;
    end
  end

  assign xfer = load_valid && !pend_full_q;

  always_comb begin
    pend_d      = pend_q;
    pend_dp_d   = pend_dp_q;
    pend_full_d = pend_full_q;
    disp_d      = disp_q;
    disp_dp_d   = disp_dp_q;
    if (xfer) begin
      pend_d      = load_data;
      pend_dp_d   = load_dp;
      pend_full_d = 1'b1;
    end
    if (start) begin
      if (pend_full_q) begin
        disp_d      = pend_q;
        disp_dp_d   = pend_dp_q;
        pend_full_d = 1'b0;
      end else if (xfer) begin
        // Empty slot at a frame start: bypass straight to display.
        disp_d      = load_data;
        disp_dp_d   = load_dp;
        pend_full_d = 1'b0;
      end
    end
  end

  // Outputs are computed from next-state values so they are registered
  // yet change on the same edge as the state/idx transition.
  always_comb begin
    nib    = '0;
    dp_bit = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_d == IW'(i)) begin
        nib    = disp_d[4*i +: 4];
        dp_bit = disp_dp_d[i];
      end
    end
`ifdef SEGSCAN_LZB_EN
    lit = (idx_d == '0);
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (disp_d[4*i +: 4] != 4'h0 && IW'(i) >= idx_d) begin
        lit = 1'b1;
      end
    end
`else
    lit = 1'b1;
`endif
  end

  hex_to_seg u_dec (
    .nib (nib),
    .seg (glyph)
  );

  always_comb begin
    an_d  = '1;
    seg_d = SEG_OFF;
    dp_d  = 1'b1;
    if (state_d == SHOW && lit) begin
      an_d[idx_d] = 1'b0;
      seg_d       = glyph;
      dp_d        = ~dp_bit;
    end
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      disp_q      <= '0;
      disp_dp_q   <= '0;
      pend_q      <= '0;
      pend_dp_q   <= '0;
      pend_full_q <= 1'b0;
      an_q        <= '1;
      seg_q       <= SEG_OFF;
      dp_q        <= 1'b1;
      fd_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      disp_q      <= disp_d;
      disp_dp_q   <= disp_dp_d;
      pend_q      <= pend_d;
      pend_dp_q   <= pend_dp_d;
      pend_full_q <= pend_full_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
      fd_q        <= fd_d;
    end
  end

  assign load_ready = ~pend_full_q;
  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Scoreboard bench for seven_seg_scanner: output run-length checks
// on a BLANK_CYCLES=2 instance and a BLANK_CYCLES=0 instance.
module tb_seven_seg_scanner;

  typedef struct packed {
    logic [13:0] key;
    int          len;
  } run_t;

  logic       clk_in = 1'b0;
  logic       rst_n;
  logic       en0;
  logic       lv0;
  logic [15:0] ld0;
  logic [3:0] ldp0;
  logic       rdy0;
  logic [6:0] seg0;
  logic       dp0;
  logic [3:0] an0;
  logic       fd0;

  logic       en1;
  logic       lv1;
  logic [15:0] ld1;
  logic [3:0] ldp1;
  logic       rdy1;
  logic [6:0] seg1;
  logic       dp1;
  logic [3:0] an1;
  logic       fd1;

  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  run_t q0[$];
  run_t q1[$];

  logic [6:0] glyph [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03,
    7'h46, 7'h21, 7'h06, 7'h0E
  };

  localparam logic [15:0] DA = 16'h12AF;
  localparam logic [3:0]  PA = 4'b0010;
  localparam logic [15:0] DB = 16'h7E36;
  localparam logic [3:0]  PB = 4'b1001;
  localparam logic [15:0] DC = 16'h0005;
  localparam logic [13:0] DARK = {1'b0, 1'b1, 4'hF, 7'h7F, 1'b1};

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) begin
    if (rst_n) cyc <= cyc + 1;
  end

  seven_seg_scanner #(
    .NUM_DIGITS   (4),
    .SCAN_DIV     (8),
    .BLANK_CYCLES (2)
  ) u0 (
    .clk_in     (clk_in),
    .reset      (rst_n),
    .enable     (en0),
    .load_valid (lv0),
    .load_ready (rdy0),
    .load_data  (ld0),
    .load_dp    (ldp0),
    .seg        (seg0),
    .dp         (dp0),
    .an         (an0),
    .frame_done (fd0)
  );

  seven_seg_scanner #(
    .NUM_DIGITS   (4),
    .SCAN_DIV     (8),
    .BLANK_CYCLES (0)
  ) u1 (
    .clk_in     (clk_in),
    .reset      (rst_n),
    .enable     (en1),
    .load_valid (lv1),
    .load_ready (rdy1),
    .load_data  (ld1),
    .load_dp    (ldp1),
    .seg        (seg1),
    .dp         (dp1),
    .an         (an1),
    .frame_done (fd1)
  );

  // Expected {frame_done, load_ready, an, seg, dp} at position pos
  // of a frame, counted from the frame-start edge.
  function automatic logic [13:0] exp_key(
    int blank, int pos, logic [15:0] disp,
    logic [3:0] dpb, bit fd_first, bit rdy
  );
    int          slen;
    int          slot;
    bit          lit;
    logic [3:0]  a;
    logic [6:0]  s;
    logic        d;
    logic [15:0] hi;
    slen = blank + 8;
    slot = pos / slen;
    lit  = (pos % slen) >= blank;
    a    = 4'hF;
    s    = 7'h7F;
    d    = 1'b1;
    hi   = disp >> (4 * slot);
`ifdef SEGSCAN_LZB_EN
    if (slot != 0 && hi == 16'h0) lit = 1'b0;
`endif
    if (lit) begin
      a[slot] = 1'b0;
      s       = glyph[hi[3:0]];
      d       = ~dpb[slot];
    end
    return {fd_first && pos == 0, rdy, a, s, d};
  endfunction

  task automatic push(int w, logic [13:0] k);
    run_t r;
    r.key = k;
    r.len = 1;
    if (w == 0) begin
      if (q0.size() > 0 && q0[q0.size()-1].key == k)
        q0[q0.size()-1].len = q0[q0.size()-1].len + 1;
      else
        q0.push_back(r);
    end else begin
      if (q1.size() > 0 && q1[q1.size()-1].key == k)
        q1[q1.size()-1].len = q1[q1.size()-1].len + 1;
      else
        q1.push_back(r);
    end
  endtask

  task automatic frm(
    int w, int blank, int p0, int p1,
    logic [15:0] disp, logic [3:0] dpb, bit fd,
    int lo_from, int lo_to
  );
    for (int p = p0; p <= p1; p++) begin
      push(w, exp_key(blank, p, disp, dpb, fd,
                      !(p >= lo_from && p <= lo_to)));
    end
  endtask

  task automatic chk(string nm, logic [15:0] got, logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, got, exp);
    end
  endtask

  task automatic chk_run(int w, logic [13:0] got, int len);
    run_t e;
    if (w == 0 && q0.size() == 0) return;
    if (w == 1 && q1.size() == 0) return;
    e = (w == 0) ? q0.pop_front() : q1.pop_front();
    n_chk++;
    if (got !== e.key || len != e.len) begin
      n_fail++;
      $display("FAIL run u%0d @cyc %0d: got key=%h len=%0d, expected key=%h len=%0d",
               w, cyc, got, len, e.key, e.len);
    end
  endtask

  initial begin : mon0
    logic [13:0] cur;
    logic [13:0] k;
    int          len;
    bit          have;
    have = 1'b0;
    len  = 0;
    cur  = '0;
    forever begin
      @(negedge clk_in);
      if (cyc >= 1 && rst_n) begin
        k = {fd0, rdy0, an0, seg0, dp0};
        if (!have) begin
          cur  = k;
          len  = 1;
          have = 1'b1;
        end else if (k == cur) begin
          len++;
        end else begin
          chk_run(0, cur, len);
          cur = k;
          len = 1;
        end
      end
    end
  end

  initial begin : mon1
    logic [13:0] cur;
    logic [13:0] k;
    int          len;
    bit          have;
    have = 1'b0;
    len  = 0;
    cur  = '0;
    forever begin
      @(negedge clk_in);
      if (cyc >= 1 && rst_n) begin
        k = {fd1, rdy1, an1, seg1, dp1};
        if (!have) begin
          cur  = k;
          len  = 1;
          have = 1'b1;
        end else if (k == cur) begin
          len++;
        end else begin
          chk_run(1, cur, len);
          cur = k;
          len = 1;
        end
      end
    end
  end

  initial begin : stim
    bit ok;
    rst_n = 1'b0;
    en0   = 1'b1;
    en1   = 1'b1;
    lv0   = 1'b0;
    ld0   = '0;
    ldp0  = '0;
    lv1   = 1'b0;
    ld1   = '0;
    ldp1  = '0;

    // u0 timeline, cycle c = posedges since reset release.
    frm(0, 2, 0, 39, 16'h0, 4'h0, 1'b0, 9, 39);
    frm(0, 2, 0, 39, DA, PA, 1'b1, 1, 39);
    frm(0, 2, 0, 39, DB, PB, 1'b1, 99, 99);
    frm(0, 2, 0, 23, DB, PB, 1'b1, 99, 99);
    for (int i = 0; i < 5; i++) push(0, DARK);
    frm(0, 2, 0, 39, DB, PB, 1'b0, 11, 39);
    frm(0, 2, 0, 39, DC, 4'h0, 1'b1, 99, 99);
    // u1: no blank interval, 32-cycle frames.
    frm(1, 0, 0, 31, 16'h0, 4'h0, 1'b0, 99, 99);
    frm(1, 0, 0, 31, 16'h0, 4'h0, 1'b1, 99, 99);

    repeat (3) @(negedge clk_in);
    chk("rst an", {12'h0, an0}, 16'hF);
    chk("rst seg", {9'h0, seg0}, 16'h7F);
    chk("rst dp", {15'h0, dp0}, 16'h1);
    chk("rst frame_done", {15'h0, fd0}, 16'h0);
    chk("rst load_ready", {15'h0, rdy0}, 16'h1);
    chk("rst u1 an", {12'h0, an1}, 16'hF);
    rst_n = 1'b1;

    while (cyc < 9) @(negedge clk_in);
    lv0  = 1'b1;
    ld0  = DA;
    ldp0 = PA;
    @(negedge clk_in);
    ld0  = DB;
    ldp0 = PB;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (rdy0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk_in);
    end
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL stall timeout: load_ready stayed 0, expected 1");
    end
    @(negedge clk_in);
    lv0 = 1'b0;

    while (cyc < 144) @(negedge clk_in);
    en0 = 1'b0;
    while (cyc < 149) @(negedge clk_in);
    en0 = 1'b1;
    while (cyc < 160) @(negedge clk_in);
    lv0  = 1'b1;
    ld0  = DC;
    ldp0 = 4'h0;
    @(negedge clk_in);
    lv0 = 1'b0;

    for (int i = 0; i < 300; i++) begin
      if (q0.size() == 0 && q1.size() == 0) break;
      @(negedge clk_in);
    end
    chk("runs left", 16'(q0.size() + q1.size()), 16'h0);

    // Asynchronous reset in the middle of a lit slot.
    while (an0 == 4'hF) @(negedge clk_in);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async an", {12'h0, an0}, 16'hF);
    chk("async seg", {9'h0, seg0}, 16'h7F);
    chk("async dp", {15'h0, dp0}, 16'h1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
